// File: rtl/pwm_pkg.sv
// Shared types for the PWM duty-ramp sequencer: default duty word and channel ramp state.
package pwm_pkg;

    localparam int PWM_CCW = 8;

    typedef logic [PWM_CCW-1:0] duty_t;

    typedef enum logic [1:0] {
        RMP_IDLE = 2'd0,
        RMP_UP   = 2'd1,
        RMP_DOWN = 2'd2
    } rmp_state_e;

endpackage

// File: rtl/pwm_ramp_chn.sv
// One ramp channel: holds current/target/step, steps current toward target once per
// accepted period tick with saturation, and pulses done when a ramp lands on target.
import pwm_pkg::*;

module pwm_ramp_chn #(
    parameter int             CCW = 8,
    parameter logic [CCW-1:0] CCE = '1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_en,
    input  logic [CCW-1:0] wr_tgt,
    input  logic [CCW-1:0] wr_stp,
    input  logic           tick,
    input  logic           frz,
    output logic [CCW-1:0] cur,
    output logic [1:0]     state,
    output logic           done
);

    logic [CCW-1:0] cur_q;
    logic [CCW-1:0] tgt_q;
    logic [CCW-1:0] stp_q;
    logic           done_q;
    rmp_state_e     st;

    logic [CCW:0]   sum;
    logic [CCW-1:0] dif;
    logic           up_hit;
    logic           dn_hit;
    logic           upd;
    logic           hit;
    logic [CCW-1:0] cur_nxt;

    // Direction comes straight from the registered cur/tgt pair, so a new target
    // written on one edge redirects the ramp from the following cycle on.
    always_comb begin
        st = RMP_IDLE;
        if (cur_q < tgt_q) begin
            st = RMP_UP;
        end else if (cur_q > tgt_q) begin
            st = RMP_DOWN;
        end
    end

    assign sum    = {1'b0, cur_q} + {1'b0, stp_q};
    assign dif    = cur_q - stp_q;
    assign up_hit = (sum >= {1'b0, tgt_q}) || (stp_q == '0);
    assign dn_hit = (cur_q < stp_q) || (dif <= tgt_q) || (stp_q == '0);
    assign upd    = tick && !frz && (st != RMP_IDLE);

    always_comb begin
        cur_nxt = cur_q;
        hit     = 1'b0;
        case (st)
            RMP_UP: begin
                hit     = up_hit;
                cur_nxt = up_hit ? tgt_q : sum[CCW-1:0];
            end
            RMP_DOWN: begin
                hit     = dn_hit;
                cur_nxt = dn_hit ? tgt_q : dif;
            end
            default: begin
                cur_nxt = cur_q;
                hit     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_q  <= '0;
            tgt_q  <= '0;
            stp_q  <= '0;
            done_q <= 1'b0;
        end else begin
            if (upd) begin
                cur_q <= cur_nxt;
            end
            done_q <= upd && hit;
            if (wr_en) begin
                tgt_q <= (wr_tgt > CCE) ? CCE : wr_tgt;
                stp_q <= wr_stp;
            end
        end
    end

    assign cur   = cur_q;
    assign state = st;
    assign done  = done_q;

endmodule

// File: rtl/pwm_ramp_ctl.sv
// Multi-channel duty ramp sequencer feeding PWM generator stream inputs; decodes the
// configuration write port and replicates one ramp channel per generator.
import pwm_pkg::*;

module pwm_ramp_ctl #(
    parameter int             CHN = 4,
    parameter int             CCW = 8,
    parameter logic [CCW-1:0] CCE = '1,
    localparam int            CHW = (CHN > 1) ? $clog2(CHN) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [CHW-1:0]     wr_ch,
    input  logic [CCW-1:0]     wr_tgt,
    input  logic [CCW-1:0]     wr_stp,
    input  logic               frz,
    input  logic [CHN-1:0]     str_rdy,
    output logic [CHN*CCW-1:0] str_dat,
    output logic [CHN-1:0]     busy,
    output logic [CHN-1:0]     done
);

    for (genvar i = 0; i < CHN; i++) begin : g_chn
        logic [1:0] st;
        logic       wr_sel;

        // Indices at or above CHN match no channel, so such writes fall away.
        assign wr_sel = wr_en && (wr_ch == CHW'(i));

        pwm_ramp_chn #(
            .CCW (CCW),
            .CCE (CCE)
        ) u_chn (
            .clk    (clk),
            .rst    (rst),
            .wr_en  (wr_sel),
            .wr_tgt (wr_tgt),
            .wr_stp (wr_stp),
            .tick   (str_rdy[i]),
            .frz    (frz),
            .cur    (str_dat[i*CCW +: CCW]),
            .state  (st),
            .done   (done[i])
        );

        assign busy[i] = (st != RMP_IDLE);
    end

endmodule

// File: tb/tb_pwm_ramp_ctl.sv
// Directed bench for pwm_ramp_ctl: per-tick expected duties queued and compared on output.
module tb_pwm_ramp_ctl;

    localparam int             CHN = 5;
    localparam int             CCW = 8;
    localparam int             CHW = 3;
    localparam logic [CCW-1:0] CCE = 8'd240;

    logic               clk;
    logic               rst;
    logic               wr_en;
    logic [CHW-1:0]     wr_ch;
    logic [CCW-1:0]     wr_tgt;
    logic [CCW-1:0]     wr_stp;
    logic               frz;
    logic [CHN-1:0]     str_rdy;
    logic [CHN*CCW-1:0] str_dat;
    logic [CHN-1:0]     busy;
    logic [CHN-1:0]     done;

    logic [CCW-1:0] exp_q[$];
    int n_err;
    int n_chk;

    pwm_ramp_ctl #(
        .CHN (CHN),
        .CCW (CCW),
        .CCE (CCE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_tgt  (wr_tgt),
        .wr_stp  (wr_stp),
        .frz     (frz),
        .str_rdy (str_rdy),
        .str_dat (str_dat),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_write(input int ch, input int tgt, input int stp);
        wr_en  = 1'b1;
        wr_ch  = CHW'(ch);
        wr_tgt = CCW'(tgt);
        wr_stp = CCW'(stp);
        cyc();
        wr_en  = 1'b0;
    endtask

    task automatic push(input int v);
        exp_q.push_back(CCW'(v));
    endtask

    task automatic gap();
        int n;
        n = $urandom_range(0, 4);
        for (int k = 0; k < n; k++) cyc();
        if (n > 0) chk("done_idle", done, '0);
    endtask

    // One period tick on channel ch; the queued value is what str_dat must show after it.
    task automatic tick(input int ch, input logic exp_done);
        logic [CCW-1:0] e;
        str_rdy[ch] = 1'b1;
        cyc();
        str_rdy = '0;
        wr_en   = 1'b0;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("str_dat%0d", ch), str_dat[ch*CCW +: CCW], e);
        end
        chk($sformatf("done%0d", ch), done[ch], exp_done);
        gap();
    endtask

    initial begin
        logic [CHN*CCW-1:0] exp_vec;
        n_err   = 0;
        n_chk   = 0;
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_ch   = '0;
        wr_tgt  = '0;
        wr_stp  = '0;
        frz     = 1'b0;
        str_rdy = '0;

        // Reset with random ticks
        for (int k = 0; k < 3; k++) begin
            str_rdy = CHN'($urandom_range(0, 31));
            cyc();
        end
        chk("rst_str_dat", str_dat, '0);
        chk("rst_busy", busy, '0);
        chk("rst_done", done, '0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            str_rdy = CHN'($urandom_range(0, 31));
            cyc();
        end
        str_rdy = '0;
        chk("post_rst_str_dat", str_dat, '0);
        chk("post_rst_busy", busy, '0);
        chk("post_rst_done", done, '0);

        // Ramp up ch0
        do_write(0, 100, 30);
        chk("busy0_up", busy[0], 1'b1);
        push(30); push(60); push(90); push(100);
        tick(0, 1'b0); tick(0, 1'b0); tick(0, 1'b0); tick(0, 1'b1);
        cyc();
        chk("done0_once", done[0], 1'b0);
        chk("busy0_end", busy[0], 1'b0);

        // Ch1 jump to 100, then ramp down with saturation, then clamp to CCE
        do_write(1, 100, 0);
        push(100);
        tick(1, 1'b1);
        do_write(1, 5, 40);
        chk("busy1_down", busy[1], 1'b1);
        push(60); push(20); push(5);
        tick(1, 1'b0); tick(1, 1'b0); tick(1, 1'b1);
        do_write(1, 250, 100);
        push(105); push(205); push(240);
        tick(1, 1'b0); tick(1, 1'b0); tick(1, 1'b1);
        chk("busy1_clamped", busy[1], 1'b0);

        // Ch2 retarget with write on a tick cycle
        do_write(2, 200, 50);
        push(50); push(100);
        tick(2, 1'b0); tick(2, 1'b0);
        wr_en  = 1'b1;
        wr_ch  = 3'd2;
        wr_tgt = 8'd20;
        wr_stp = 8'd10;
        push(150);
        tick(2, 1'b0);
        chk("busy2_rev", busy[2], 1'b1);
        for (int v = 140; v >= 20; v -= 10) begin
            push(v);
            tick(2, (v == 20));
        end
        chk("busy2_end", busy[2], 1'b0);

        // Ch3 freeze mid-ramp
        do_write(3, 100, 20);
        push(20); push(40);
        tick(3, 1'b0); tick(3, 1'b0);
        frz = 1'b1;
        for (int k = 0; k < 5; k++) begin
            push(40);
            tick(3, 1'b0);
            chk("busy3_frz", busy[3], 1'b1);
        end
        frz = 1'b0;
        push(60); push(80); push(100);
        tick(3, 1'b0); tick(3, 1'b0); tick(3, 1'b1);

        // Ch4 immediate jump, equal-target write, ignored writes
        do_write(4, 77, 0);
        push(77);
        tick(4, 1'b1);
        do_write(4, 77, 5);
        chk("busy4_eq", busy[4], 1'b0);
        push(77);
        tick(4, 1'b0);
        do_write(5, 3, 1);
        do_write(7, 9, 2);
        chk("busy_ign", busy, '0);
        str_rdy = '1;
        cyc();
        str_rdy = '0;
        exp_vec = {8'd77, 8'd100, 8'd20, 8'd240, 8'd100};
        chk("str_dat_ign", str_dat, exp_vec);
        chk("done_ign", done, '0);

        // Reset mid-ramp clears everything at once
        do_write(0, 200, 10);
        push(110);
        tick(0, 1'b0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst_str_dat", str_dat, '0);
        chk("midrst_busy", busy, '0);
        chk("midrst_done", done, '0);
        cyc();
        rst = 1'b0;
        cyc();
        chk("after_midrst_str_dat", str_dat, '0);
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
